fifo_drain_packer: RTL

Downstream consumer of the synchronous FIFO. Pops IN_WIDTH-bit words through the FIFO's read port, accounts for the FIFO's one-cycle registered read latency, and packs PACK consecutive words into one wide beat on a valid/ready output stream. A flush request emits a trailing partial beat with a lane-keep mask. Underflow is tracked with a sticky error flag.

---
 rtl/fifo_drain_packer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fifo_drain_packer.sv
// fifo_drain_packer: drains a synchronous FIFO (one-cycle registered read latency)
// and packs PACK words per valid/ready beat. A flush emits a partial beat with a keep mask.
module fifo_drain_packer #(
  parameter int IN_WIDTH = 16,
  parameter int PACK     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fifo_empty,
  input  logic                     fifo_underflow,
  input  logic [IN_WIDTH-1:0]      fifo_data_out,
  output logic                     fifo_rd_en,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IN_WIDTH*PACK-1:0] out_data,
  output logic [PACK-1:0]          out_keep,
  output logic                     err_underflow,
  output logic [15:0]              beats_out
);
  localparam int            FW        = $clog2(PACK + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(PACK);
  localparam logic [FW:0]   PACK_W    = (FW + 1)'(PACK);

  typedef enum logic {FILL, FLUSH} state_t;

  state_t                             state_q, state_d;
  logic                               flush_req_p1, flush_req_d;
  logic                               pend_p1;
  logic [FW-1:0]                      fill_p1;
  logic [PACK-1:0][IN_WIDTH-1:0]      acc_p1;
  logic                               vld_p2;
  logic [IN_WIDTH*PACK-1:0]           data_p2;
  logic [PACK-1:0]                    keep_p2;
  logic                               err_q;
  logic [15:0]                        beats_q;

  logic [FW:0] occ;
  logic        obuf_free, full_beat, part_beat, xfer;
  logic        land, cap, drop;

  function automatic logic [PACK-1:0] keep_mask(input logic [FW-1:0] n);
    logic [PACK-1:0] m;
    m = '0;
    for (int i = 0; i < PACK; i++) m[i] = (FW'(i) < n);
    return m;
  endfunction

  // Lanes at or above the fill count are forced to zero so stale words never leak.
  function automatic logic [IN_WIDTH*PACK-1:0] pack_lanes(
    input logic [PACK-1:0][IN_WIDTH-1:0] lanes,
    input logic [FW-1:0]                 n
  );
    logic [IN_WIDTH*PACK-1:0] b;
    b = '0;
    for (int i = 0; i < PACK; i++)
      if (FW'(i) < n) b[i*IN_WIDTH +: IN_WIDTH] = lanes[i];
    return b;
  endfunction

  always_comb begin
    occ        = {1'b0, fill_p1} + {{FW{1'b0}}, pend_p1};
    obuf_free  = !vld_p2 || out_ready;
    full_beat  = (fill_p1 == FILL_FULL);
    part_beat  = flush_req_p1 && !pend_p1 && (fill_p1 != '0);
    xfer       = (full_beat || part_beat) && obuf_free;
    land       = pend_p1 && (fill_p1 != FILL_FULL);
    cap        = land && !fifo_underflow;
    drop       = land && fifo_underflow;
    fifo_rd_en = !rst && (state_q == FILL) && !fifo_empty && (occ < PACK_W);
  end

  // A read issued in the flush cycle counts as data in flight for the partial beat.
  always_comb begin
    state_d     = state_q;
    flush_req_d = flush_req_p1;
    case (state_q)
      FILL: begin
        if (flush && ((fill_p1 != '0) || pend_p1 || fifo_rd_en)) begin
          state_d     = FLUSH;
          flush_req_d = 1'b1;
        end
      end
      FLUSH: begin
        if (xfer || (drop && (fill_p1 == '0)) || (!pend_p1 && (fill_p1 == '0))) begin
          state_d     = FILL;
          flush_req_d = 1'b0;
        end
      end
    endcase
  end

  // p0 -> p1: read request in flight, landing word captured into the accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      flush_req_p1 <= 1'b0;
      pend_p1      <= 1'b0;
      fill_p1      <= '0;
    end else begin
      state_q      <= state_d;
      flush_req_p1 <= flush_req_d;
      pend_p1      <= fifo_rd_en || (pend_p1 && !land);
      if (xfer)     fill_p1 <= '0;
      else if (cap) fill_p1 <= fill_p1 + FW'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < PACK; i++)
      if (cap && (fill_p1 == FW'(i))) acc_p1[i] <= fifo_data_out;
  end

  // p1 -> p2: accumulator moves into the output register when it is free
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      keep_p2 <= '0;
      err_q   <= 1'b0;
      beats_q <= '0;
    end else begin
      if (vld_p2 && out_ready) beats_q <= beats_q + 16'd1;
      if (drop) err_q <= 1'b1;
      if (xfer) begin
        vld_p2  <= 1'b1;
        data_p2 <= pack_lanes(acc_p1, fill_p1);
        keep_p2 <= keep_mask(fill_p1);
      end else if (out_ready) begin
        vld_p2  <= 1'b0;
      end
    end
  end

  assign out_valid     = vld_p2;
  assign out_data      = data_p2;
  assign out_keep      = keep_p2;
  assign err_underflow = err_q;
  assign beats_out     = beats_q;

  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (vld_p2 && !out_ready) |=> (vld_p2 && $stable(data_p2) && $stable(keep_p2)));

  a_no_overread: assert property (@(posedge clk) disable iff (rst) occ <= PACK_W);

endmodule
